id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports in_valid input 1 (decoded instruction present), stall input 1 (hold stage), flush input 1 (kill stage contents).
REQ-004 SHALL have ports opcode input 6, funct input 6, shamt_in input 5, imm16 input 16, rs_addr/rt_addr/rd_addr input 5 each, rs_data/rt_data input 32 each (register-file read values).
REQ-005 SHALL have forwarding ports ex_mem_wr input 1, ex_mem_rd input 5, ex_mem_result input 32, mem_wb_wr input 1, mem_wb_rd input 5, mem_wb_result input 32.
REQ-006 SHALL have outputs first output 32, second output 32, op output 4, shamt output 5; these drive the 32-bit ALU directly.
REQ-007 SHALL have outputs dest output 5 (write-back register), reg_write output 1, mem_read output 1, mem_write output 1, store_data output 32, out_valid output 1, illegal output 1.

Function
REQ-008 SHALL register all outputs; one-cycle latency from capture edge to outputs.
REQ-009 SHALL decode op codes: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100, sll 1101, srl 1110.
REQ-010 SHALL decode opcode 0 by funct: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl; dest=rd_addr, reg_write=1.
REQ-011 SHALL decode I-type: 0x08/0x09 add sign-ext imm; 0x0A slt sign-ext; 0x0C and zero-ext; 0x0D or zero-ext; 0x23 lw add sign-ext, mem_read=1; 0x2B sw add sign-ext, mem_write=1, reg_write=0; 0x04 beq sub with second=rt, reg_write=0; dest=rt_addr for writing I-types.
REQ-012 SHALL, for sll/srl, set first=forwarded rt value, second=0, shamt=shamt_in; for all other ops shamt=0.
REQ-013 SHALL resolve each source operand (rs, rt) at capture: ex_mem_result if ex_mem_wr and ex_mem_rd==addr; else mem_wb_result if mem_wb_wr and mem_wb_rd==addr; else register-file data.
REQ-014 SHALL never forward for address 0; register 0 source always reads rs_data/rt_data as given.
REQ-015 SHALL set store_data = forwarded rt value for sw, 0 otherwise.
REQ-016 SHALL force reg_write=0 when decoded dest is 0.
REQ-017 SHALL treat any unlisted opcode/funct with in_valid=1 as illegal: capture a bubble (out_valid=0, all control 0) and pulse illegal=1 for exactly one cycle.
REQ-018 SHALL, on an edge with in_valid=0 and no stall, capture a bubble.
REQ-019 SHALL apply per-edge priority: reset > flush > stall > capture.
REQ-020 SHALL, on flush, capture a bubble regardless of stall and in_valid; illegal=0.
REQ-021 SHALL, on stall without flush, hold every output unchanged, except illegal which SHALL be 0.
REQ-022 SHALL, on a bubble, drive first, second, store_data to 0, op to 0010, shamt and dest to 0.

Reset
REQ-023 SHALL, on clk edge with reset=1, set out_valid, reg_write, mem_read, mem_write, illegal to 0, first/second/store_data to 0, op to 0010, shamt/dest to 0.
REQ-024 SHALL let reset mid-stall or mid-flush discard held contents; first capture occurs on the first edge after reset deasserts.

Verification
REQ-025 add $3,$1,$2 (rs_data=5, rt_data=7, no forward) -> next cycle first=5, second=7, op=0010, dest=3, reg_write=1, out_valid=1.
REQ-026 Same add, ex_mem_wr=1 ex_mem_rd=1 ex_mem_result=100, mem_wb_wr=1 mem_wb_rd=1 mem_wb_result=200 -> first=100; with ex_mem_wr=0 -> first=200; with rs_addr=0 and both forwards to rd 0 -> first=rs_data.
REQ-027 addi $4,$1,-1 (imm16=0xFFFF, rs_data=1) -> first=1, second=0xFFFFFFFF, op=0010, dest=4; andi with imm16=0xFFFF -> second=0x0000FFFF, op=0000.
REQ-028 sll $2,$5,4 (rt_data=3) -> first=3, second=0, op=1101, shamt=4, dest=2.
REQ-029 Capture add, then stall=1 for 3 cycles with new inputs -> outputs unchanged; stall=1 and flush=1 together -> out_valid=0, reg_write=0 next cycle.
REQ-030 opcode 0x3F with in_valid=1 -> illegal=1 for one cycle, out_valid=0; reset asserted during a held sw -> mem_write=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with decode and operand forwarding.
//
// Captures one decoded instruction per clock. On capture it resolves the rs/rt
// source operands against the EX/MEM and MEM/WB forwarding paths, translates
// the opcode/funct pair into a 4-bit ALU op, and builds the two ALU operands.
// Every output is a register, so results appear one cycle after capture.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   in_valid, stall, flush     stage control (reset > flush > stall > capture)
//   opcode, funct, shamt_in,   instruction fields from decode
//   imm16, rs/rt/rd_addr
//   rs_data, rt_data           register-file read values
//   ex_mem_*, mem_wb_*         forwarding sources (write enable, dest, value)
//   first, second, op, shamt   ALU operands and operation
//   dest, reg_write            write-back register and enable
//   mem_read, mem_write,       memory controls and store value
//   store_data
//   out_valid                  stage holds a real instruction
//   illegal                    one-cycle pulse when an unknown encoding was seen
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt_in,
    input  logic [15:0] imm16,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_mem_wr,
    input  logic [4:0]  ex_mem_rd,
    input  logic [31:0] ex_mem_result,
    input  logic        mem_wb_wr,
    input  logic [4:0]  mem_wb_rd,
    input  logic [31:0] mem_wb_result,
    output logic [31:0] first,
    output logic [31:0] second,
    output logic [3:0]  op,
    output logic [4:0]  shamt,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] store_data,
    output logic        out_valid,
    output logic        illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1101;
    localparam logic [3:0] OP_SRL = 4'b1110;

    // ------------------------------------------------------------------
    // Operand forwarding: index 0 is rs, index 1 is rt. The nearer stage
    // (EX/MEM) wins over MEM/WB; register 0 is never forwarded.
    // ------------------------------------------------------------------
    logic [4:0]  src_addr [2];
    logic [31:0] src_data [2];
    logic [31:0] fwd_val  [2];

    assign src_addr[0] = rs_addr;
    assign src_addr[1] = rt_addr;
    assign src_data[0] = rs_data;
    assign src_data[1] = rt_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                if (src_addr[gi] == 5'd0)
                    fwd_val[gi] = src_data[gi];
                else if (ex_mem_wr && (ex_mem_rd == src_addr[gi]))
                    fwd_val[gi] = ex_mem_result;
                else if (mem_wb_wr && (mem_wb_rd == src_addr[gi]))
                    fwd_val[gi] = mem_wb_result;
                else
                    fwd_val[gi] = src_data[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode of the instruction currently at the inputs.
    // ------------------------------------------------------------------
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        dec_legal;
    logic [31:0] first_next;
    logic [31:0] second_next;
    logic [3:0]  op_next;
    logic [4:0]  shamt_next;
    logic [4:0]  dest_next;
    logic        reg_write_next;
    logic        mem_read_next;
    logic        mem_write_next;
    logic [31:0] store_data_next;

    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'd0, imm16};

    always_comb begin
        dec_legal       = 1'b1;
        first_next      = fwd_val[0];
        second_next     = fwd_val[1];
        op_next         = OP_ADD;
        shamt_next      = 5'd0;
        dest_next       = 5'd0;
        reg_write_next  = 1'b0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        store_data_next = 32'd0;

        case (opcode)
            6'h00: begin
                dest_next      = rd_addr;
                reg_write_next = 1'b1;
                case (funct)
                    6'h20, 6'h21: op_next = OP_ADD;
                    6'h22, 6'h23: op_next = OP_SUB;
                    6'h24:        op_next = OP_AND;
                    6'h25:        op_next = OP_OR;
                    6'h27:        op_next = OP_NOR;
                    6'h2A:        op_next = OP_SLT;
                    6'h00, 6'h02: begin
                        // Shifts operate on rt; the amount travels separately.
                        op_next     = (funct == 6'h00) ? OP_SLL : OP_SRL;
                        first_next  = fwd_val[1];
                        second_next = 32'd0;
                        shamt_next  = shamt_in;
                    end
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                op_next = OP_ADD; second_next = imm_sext;
                dest_next = rt_addr; reg_write_next = 1'b1;
            end
            6'h0A: begin
                op_next = OP_SLT; second_next = imm_sext;
                dest_next = rt_addr; reg_write_next = 1'b1;
            end
            6'h0C: begin
                op_next = OP_AND; second_next = imm_zext;
                dest_next = rt_addr; reg_write_next = 1'b1;
            end
            6'h0D: begin
                op_next = OP_OR; second_next = imm_zext;
                dest_next = rt_addr; reg_write_next = 1'b1;
            end
            6'h23: begin
                op_next = OP_ADD; second_next = imm_sext;
                dest_next = rt_addr; reg_write_next = 1'b1;
                mem_read_next = 1'b1;
            end
            6'h2B: begin
                op_next = OP_ADD; second_next = imm_sext;
                mem_write_next = 1'b1; store_data_next = fwd_val[1];
            end
            6'h04: begin
                // Branch compare: rs - rt, no register result.
                op_next = OP_SUB;
            end
            default: dec_legal = 1'b0;
        endcase

        // Writes to register 0 are discarded.
        if (dest_next == 5'd0)
            reg_write_next = 1'b0;
    end

    // ------------------------------------------------------------------
    // Stage register.
    // ------------------------------------------------------------------
    logic [31:0] first_reg;
    logic [31:0] second_reg;
    logic [3:0]  op_reg;
    logic [4:0]  shamt_reg;
    logic [4:0]  dest_reg;
    logic        reg_write_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [31:0] store_data_reg;
    logic        out_valid_reg;
    logic        illegal_reg;

    logic capture;
    logic make_bubble;

    assign capture     = !reset && !flush && !stall && in_valid && dec_legal;
    assign make_bubble = reset || flush || (!stall && !capture);

    always_ff @(posedge clk) begin
        if (make_bubble) begin
            first_reg      <= 32'd0;
            second_reg     <= 32'd0;
            op_reg         <= OP_ADD;
            shamt_reg      <= 5'd0;
            dest_reg       <= 5'd0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            store_data_reg <= 32'd0;
            out_valid_reg  <= 1'b0;
        end else if (capture) begin
            first_reg      <= first_next;
            second_reg     <= second_next;
            op_reg         <= op_next;
            shamt_reg      <= shamt_next;
            dest_reg       <= dest_next;
            reg_write_reg  <= reg_write_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            store_data_reg <= store_data_next;
            out_valid_reg  <= 1'b1;
        end
        // Illegal only flags an unknown encoding that would otherwise have
        // been captured; reset, flush and stall all suppress it.
        illegal_reg <= !reset && !flush && !stall && in_valid && !dec_legal;
    end

    assign first      = first_reg;
    assign second     = second_reg;
    assign op         = op_reg;
    assign shamt      = shamt_reg;
    assign dest       = dest_reg;
    assign reg_write  = reg_write_reg;
    assign mem_read   = mem_read_reg;
    assign mem_write  = mem_write_reg;
    assign store_data = store_data_reg;
    assign out_valid  = out_valid_reg;
    assign illegal    = illegal_reg;

endmodule
